load_store_unit: RTL and testbench

//  Sits between the core's execute/memory stage and the word-organised data memory.
//  - Turns RV32 loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses with per-byte write enables.
//  - Rotates store data onto the correct byte lanes.
//  - Extracts and sign/zero-extends load data.
//  - Splits misaligned accesses into two word accesses through a small FSM.

---
 rtl/lsu_pkg.sv | 51 +++++
 rtl/lsu_lane_gen.sv | 41 ++++
 rtl/load_store_unit.sv | 159 +++++++++++++++
 tb/tb_load_store_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared funct3 codes, FSM state encoding and decode helpers
//               for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    // Access size in bytes from funct3[1:0].
    function automatic logic [2:0] lsu_size(input logic [1:0] f3_lo);
        case (f3_lo)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic lsu_illegal(input logic we, input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
    endfunction

    function automatic logic lsu_misaligned(input logic [1:0] off, input logic [2:0] size);
        return ({2'b00, off} + {1'b0, size}) > 4'd4;
    endfunction

    function automatic logic [31:0] lsu_extend(input logic [2:0] f3, input logic [31:0] raw);
        case (f3)
            F3_B:    return {{24{raw[7]}}, raw[7:0]};
            F3_H:    return {{16{raw[15]}}, raw[15:0]};
            F3_BU:   return {24'd0, raw[7:0]};
            F3_HU:   return {16'd0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_gen.sv
`default_nettype none
// ============================================================================
// Module      : lsu_lane_gen
// Description : Byte-lane write enables and lane-rotated store data for one
//               word access (phase 0 = first word, phase 1 = spill word).
// Revision    : 1.0 - initial release
// ============================================================================
import lsu_pkg::*;

module lsu_lane_gen (
    input  logic [1:0]  off,
    input  logic [2:0]  size,
    input  logic        phase,
    input  logic [31:0] wdata,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_din
);

    logic [3:0] w_base;
    logic [7:0] w_span;

    always_comb begin
        case (size)
            3'd1:    w_base = 4'b0001;
            3'd2:    w_base = 4'b0011;
            default: w_base = 4'b1111;
        endcase
        // Lanes past byte 3 spill into the low lanes of the next word.
        w_span = {4'b0000, w_base} << off;
        mem_we = phase ? w_span[7:4] : w_span[3:0];

        case (off)
            2'd0:    mem_din = wdata;
            2'd1:    mem_din = {wdata[23:0], wdata[31:24]};
            2'd2:    mem_din = {wdata[15:0], wdata[31:16]};
            default: mem_din = {wdata[7:0],  wdata[31:8]};
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : RV32 load/store to word-memory adapter. Misaligned accesses
//               are split in two when LSU_MISALIGN_SPLIT_EN is defined,
//               otherwise they return an error without touching memory.
// Revision    : 1.0 - initial release
// ============================================================================
import lsu_pkg::*;

module load_store_unit #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic [3:0]    mem_we,
    input  logic [DW-1:0] mem_dout
);

    lsu_state_e    r_state;
    lsu_state_e    w_state_nxt;
    logic [AW-1:0] r_addr;
    logic          r_we;
    logic [2:0]    r_funct3;
    logic [DW-1:0] r_wdata;

    logic [1:0]    w_off;
    logic [2:0]    w_size;
    logic          w_req_err;
    logic          w_in_acc;
    logic          w_done;
    logic [AW-1:0] w_word_addr;
    logic [3:0]    w_lane_we;
    logic [31:0]   w_lane_din;
    logic [31:0]   w_lo;
    logic [23:0]   w_hi;
    logic [31:0]   w_raw;

    assign w_off  = r_addr[1:0];
    assign w_size = lsu_size(r_funct3[1:0]);

`ifdef LSU_MISALIGN_SPLIT_EN
    logic        w_misal;
    logic [31:0] r_w0;

    assign w_misal   = lsu_misaligned(w_off, w_size);
    assign w_req_err = lsu_illegal(req_we, req_funct3);
    assign w_lo      = (r_state == ACC1) ? r_w0 : mem_dout;
    assign w_hi      = (r_state == ACC1) ? mem_dout[23:0] : 24'd0;
`else
    assign w_req_err = lsu_illegal(req_we, req_funct3) ||
                       lsu_misaligned(req_addr[1:0], lsu_size(req_funct3[1:0]));
    assign w_lo      = mem_dout;
    assign w_hi      = 24'd0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_state_nxt = w_req_err ? RESP : ACC0;
                end
            end
            ACC0: begin
`ifdef LSU_MISALIGN_SPLIT_EN
                w_state_nxt = w_misal ? ACC1 : RESP;
`else
                w_state_nxt = RESP;
`endif
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ACC1:    w_state_nxt = RESP;
`endif
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign req_ready   = (r_state == IDLE);
    assign rsp_valid   = (r_state == RESP);
    assign w_in_acc    = (r_state == ACC0) || (r_state == ACC1);
    assign w_done      = ((r_state == ACC0) && (w_state_nxt == RESP)) || (r_state == ACC1);
    assign w_word_addr = {r_addr[AW-1:2], 2'b00};

    lsu_lane_gen u_lane_gen (
        .off     (w_off),
        .size    (w_size),
        .phase   (r_state == ACC1),
        .wdata   (r_wdata),
        .mem_we  (w_lane_we),
        .mem_din (w_lane_din)
    );

    // Bus outputs depend only on registered state so reset clears them at once.
    assign mem_we   = (w_in_acc && r_we) ? w_lane_we : 4'b0000;
    assign mem_din  = w_in_acc ? w_lane_din : '0;
    assign mem_addr = (r_state == ACC0) ? w_word_addr :
                      (r_state == ACC1) ? w_word_addr + AW'(4) : '0;

    always_comb begin
        case (w_off)
            2'd0:    w_raw = w_lo;
            2'd1:    w_raw = {w_hi[7:0],  w_lo[31:8]};
            2'd2:    w_raw = {w_hi[15:0], w_lo[31:16]};
            default: w_raw = {w_hi[23:0], w_lo[31:24]};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_funct3  <= 3'b000;
            r_wdata   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            r_w0      <= 32'd0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (req_valid && req_ready) begin
                r_addr   <= req_addr;
                r_we     <= req_we;
                r_funct3 <= req_funct3;
                r_wdata  <= req_wdata;
                if (w_req_err) begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b1;
                end
            end
            if (w_done) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= r_we ? '0 : lsu_extend(r_funct3, w_raw);
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            if (r_state == ACC0) begin
                r_w0 <= mem_dout;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed and random checks of load_store_unit against a
//               byte-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [3:0]  mem_we;
    logic [31:0] mem_dout;

    always #5 clk = ~clk;

    load_store_unit #(.AW(32), .DW(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_we     (mem_we),
        .mem_dout   (mem_dout)
    );

    // Data memory: 1 KiB, combinational read, byte writes on negedge.
    logic [31:0] dmem [0:255];
    logic        clr = 1'b1;
    assign mem_dout = dmem[mem_addr[9:2]];

    always @(negedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) dmem[i] <= 32'd0;
        end else begin
            for (int l = 0; l < 4; l++)
                if (mem_we[l]) dmem[mem_addr[9:2]][8*l +: 8] <= mem_din[8*l +: 8];
        end
    end

    logic [7:0]  ref_mem [0:1023];
    int          total = 0;
    int          bad = 0;
    int          o_lat;
    logic [3:0]  s_we   [1:6];
    logic [31:0] s_addr [1:6];
    logic [31:0] s_din  [1:6];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd);
        int          sz;
        int          off;
        int          lane;
        int          lat_e;
        logic        err_e;
        logic [31:0] rd_e;
        logic [31:0] din_e;
        logic [31:0] word;
        logic [3:0]  we0_e;
        logic [3:0]  we1_e;

        sz    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        off   = int'(addr[1:0]);
        err_e = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]) ||
                (!SPLIT && (off + sz > 4));
        we0_e = 4'b0000;
        we1_e = 4'b0000;
        rd_e  = 32'd0;
        din_e = (off == 0) ? wd : ((wd << (8*off)) | (wd >> (32 - 8*off)));
        if (err_e) begin
            lat_e = 1;
        end else begin
            lat_e = (off + sz > 4) ? 3 : 2;
            if (we) begin
                for (int i = 0; i < sz; i++) begin
                    lane = off + i;
                    if (lane < 4) we0_e[lane] = 1'b1;
                    else          we1_e[lane-4] = 1'b1;
                    ref_mem[(addr + 32'(i)) & 32'h3FF] = wd[8*i +: 8];
                end
            end else begin
                word = 32'd0;
                for (int i = 0; i < sz; i++)
                    word = word | (32'(ref_mem[(addr + 32'(i)) & 32'h3FF]) << (8*i));
                if (f3 == 3'd0 && word[7])  word = word | 32'hFFFF_FF00;
                if (f3 == 3'd1 && word[15]) word = word | 32'hFFFF_0000;
                rd_e = word;
            end
        end

        @(negedge clk);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        o_lat = 0;
        for (int c = 1; c <= 6; c++) begin
            s_we[c]   = mem_we;
            s_addr[c] = mem_addr;
            s_din[c]  = mem_din;
            if (rsp_valid) begin
                o_lat = c;
                break;
            end
            @(posedge clk); #1;
        end

        chk({tag, "_lat"},   32'(o_lat), 32'(lat_e));
        chk({tag, "_err"},   32'(rsp_err), 32'(err_e));
        chk({tag, "_rdata"}, rsp_rdata, rd_e);
        if (lat_e == 1) begin
            chk({tag, "_we_err"}, 32'(s_we[1]), 32'd0);
        end else begin
            chk({tag, "_we0"},   32'(s_we[1]), 32'(we0_e));
            chk({tag, "_addr0"}, s_addr[1], {addr[31:2], 2'b00});
            if (we) chk({tag, "_din0"}, s_din[1], din_e);
        end
        if (lat_e == 3) begin
            chk({tag, "_we1"},   32'(s_we[2]), 32'(we1_e));
            chk({tag, "_addr1"}, s_addr[2], {addr[31:2], 2'b00} + 32'd4);
            if (we) chk({tag, "_din1"}, s_din[2], din_e);
        end

        @(posedge clk); #1;
        chk({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_hold"},  rsp_rdata, rd_e);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'd0;

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err",   32'(rsp_err), 32'd0);
        chk("rst_we",    32'(mem_we), 32'd0);
        chk("rst_addr",  mem_addr, 32'd0);
        chk("rst_din",   mem_din, 32'd0);
        rst_n = 1'b1;
        clr   = 1'b0;

        run_op("t1_sw", 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF);
        chk("t1_sw_we", 32'(s_we[1]), 32'hF);
        run_op("t1_lw", 1'b0, 3'b010, 32'h100, 32'd0);
        chk("t1_lw_val", rsp_rdata, 32'hDEAD_BEEF);
        chk("t1_lw_lat", 32'(o_lat), 32'd2);

        run_op("t2_lb", 1'b0, 3'b000, 32'h103, 32'd0);
        chk("t2_lb_val", rsp_rdata, 32'hFFFF_FFDE);
        run_op("t2_lbu", 1'b0, 3'b100, 32'h103, 32'd0);
        chk("t2_lbu_val", rsp_rdata, 32'h0000_00DE);
        run_op("t2_lhu", 1'b0, 3'b101, 32'h102, 32'd0);
        chk("t2_lhu_val", rsp_rdata, 32'h0000_DEAD);

        run_op("t3_sh", 1'b1, 3'b001, 32'h102, 32'h0000_1234);
        chk("t3_sh_we",  32'(s_we[1]), 32'hC);
        chk("t3_sh_din", s_din[1], 32'h1234_0000);
        chk("t3_sh_lat", 32'(o_lat), 32'd2);
        run_op("t3_lw", 1'b0, 3'b010, 32'h100, 32'd0);
        chk("t3_lw_val", rsp_rdata, 32'h1234_BEEF);

`ifdef LSU_MISALIGN_SPLIT_EN
        run_op("t4_sw", 1'b1, 3'b010, 32'h103, 32'hAABB_CCDD);
        chk("t4_addr0", s_addr[1], 32'h100);
        chk("t4_we0",   32'(s_we[1]), 32'h8);
        chk("t4_din0",  s_din[1], 32'hDDAA_BBCC);
        chk("t4_addr1", s_addr[2], 32'h104);
        chk("t4_we1",   32'(s_we[2]), 32'h7);
        run_op("t4_lw", 1'b0, 3'b010, 32'h103, 32'd0);
        chk("t4_lw_val", rsp_rdata, 32'hAABB_CCDD);
        chk("t4_lw_lat", 32'(o_lat), 32'd3);
`else
        run_op("t5_mis", 1'b0, 3'b010, 32'h101, 32'd0);
        chk("t5_mis_err", 32'(rsp_err), 32'd1);
        chk("t5_mis_lat", 32'(o_lat), 32'd1);
        chk("t5_mis_we",  32'(s_we[1]), 32'd0);
`endif
        run_op("t5_f3", 1'b0, 3'b011, 32'h200, 32'd0);
        chk("t5_f3_err", 32'(rsp_err), 32'd1);
        run_op("t5_sbu", 1'b1, 3'b100, 32'h204, 32'h55);
        chk("t5_sbu_err", 32'(rsp_err), 32'd1);

        for (int n = 0; n < 300; n++) begin
            run_op("rnd", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   32'($urandom_range(0, 1023)), $urandom);
        end

        // Reset in the middle of a store: completed byte writes persist.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_wdata  = 32'h1122_3344;
`ifdef LSU_MISALIGN_SPLIT_EN
        req_addr = 32'h2FE;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("t6_we0", 32'(mem_we), 32'hC);
        @(posedge clk); #1;
        chk("t6_we1", 32'(mem_we), 32'h3);
        ref_mem[32'h2FE] = 8'h44;
        ref_mem[32'h2FF] = 8'h33;
`else
        req_addr = 32'h2F0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("t6_we0", 32'(mem_we), 32'hF);
`endif
        rst_n = 1'b0;
        #1;
        chk("t6_rst_we",    32'(mem_we), 32'd0);
        chk("t6_rst_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("t6_idle_ready", 32'(req_ready), 32'd1);
            chk("t6_idle_valid", 32'(rsp_valid), 32'd0);
        end
        run_op("t6_lw_a", 1'b0, 3'b010, 32'h2FC, 32'd0);
        run_op("t6_lw_b", 1'b0, 3'b010, 32'h2F0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
